// File: rtl/qtable_policy_reader.sv
// Greedy-policy extractor: scans every grid state, reads the four action Q values
// and emits one {state, argmax action, max Q} record per state over a valid/ready port.
module qtable_policy_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_STATES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic [7:0]            q_rd_addr,
    output logic                  q_rd_en,
    input  logic [DATA_WIDTH-1:0] q_rd_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [5:0]            o_state,
    output logic [1:0]            o_action,
    output logic [DATA_WIDTH-1:0] o_qmax,
    output logic                  o_done
);

    localparam logic [5:0] LAST_STATE = 6'(NUM_STATES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EVAL,
        OUT,
        DONE
    } state_t;

    state_t                state;
    logic [5:0]            cnt;
    logic                  rd_pend;
    logic [1:0]            pend_act;
    logic [DATA_WIDTH-1:0] best_q;
    logic [1:0]            best_a;
    logic [DATA_WIDTH-1:0] cand_q;
    logic [1:0]            cand_a;

    // Running argmax including the data returning this cycle; strict compare keeps the lower action on ties
    always_comb begin
        cand_q = best_q;
        cand_a = best_a;
        if (pend_act == 2'b00 || q_rd_data > best_q) begin
            cand_q = q_rd_data;
            cand_a = pend_act;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            rd_pend   <= 1'b0;
            pend_act  <= 2'b00;
            best_q    <= '0;
            best_a    <= 2'b00;
            busy      <= 1'b0;
            q_rd_en   <= 1'b0;
            q_rd_addr <= 8'd0;
            o_valid   <= 1'b0;
            o_state   <= 6'd0;
            o_action  <= 2'b00;
            o_qmax    <= '0;
            o_done    <= 1'b0;
        end else begin
            // Read data arrives one cycle after its enable; track which action it belongs to
            rd_pend  <= q_rd_en;
            pend_act <= q_rd_addr[1:0];
            if (rd_pend) begin
                best_q <= cand_q;
                best_a <= cand_a;
            end
            o_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        cnt       <= 6'd0;
                        busy      <= 1'b1;
                        q_rd_en   <= 1'b1;
                        q_rd_addr <= {6'd0, 2'b00};
                        state     <= READ;
                    end
                end
                READ: begin
                    // Entry from OUT arrives with the enable low: issue the first read of the new state
                    if (!q_rd_en) begin
                        q_rd_en   <= 1'b1;
                        q_rd_addr <= {cnt, 2'b00};
                    end else if (q_rd_addr[1:0] == 2'b11) begin
                        q_rd_en <= 1'b0;
                        state   <= EVAL;
                    end else begin
                        q_rd_addr <= q_rd_addr + 8'd1;
                    end
                end
                EVAL: begin
                    o_valid  <= 1'b1;
                    o_state  <= cnt;
                    o_action <= cand_a;
                    o_qmax   <= cand_q;
                    state    <= OUT;
                end
                OUT: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        if (cnt == LAST_STATE) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cnt   <= cnt + 6'd1;
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qtable_policy_reader.sv
// Directed bench for qtable_policy_reader: behavioural Q-table memory, reference argmax,
// cycle-accurate latency/period checks, backpressure, abort by reset and ignored restart.
module tb_qtable_policy_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic [7:0] q_rd_addr;
    logic       q_rd_en;
    logic [7:0] q_rd_data;
    logic       o_valid;
    logic       o_ready;
    logic [5:0] o_state;
    logic [1:0] o_action;
    logic [7:0] o_qmax;
    logic       o_done;

    logic [7:0] mem [256];
    int n_assert = 0;
    int n_fail   = 0;
    bit tie_case = 1'b0;

    qtable_policy_reader #(.DATA_WIDTH(8), .NUM_STATES(64)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .q_rd_addr(q_rd_addr), .q_rd_en(q_rd_en), .q_rd_data(q_rd_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_state(o_state),
        .o_action(o_action), .o_qmax(o_qmax), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Synchronous-read table: data valid the cycle after the enable
    always @(posedge clk) if (q_rd_en) q_rd_data <= mem[q_rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] ref_best(input int s);
        logic [7:0] bq;
        logic [1:0] ba;
        bq = mem[s*4];
        ba = 2'd0;
        for (int a = 1; a < 4; a++) begin
            if (mem[s*4+a] > bq) begin
                bq = mem[s*4+a];
                ba = 2'(a);
            end
        end
        return {ba, bq};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   32'(busy),      0);
        chk({tag, "_rd_en"},  32'(q_rd_en),   0);
        chk({tag, "_valid"},  32'(o_valid),   0);
        chk({tag, "_done"},   32'(o_done),    0);
        chk({tag, "_addr"},   32'(q_rd_addr), 0);
        chk({tag, "_state"},  32'(o_state),   0);
        chk({tag, "_action"}, 32'(o_action),  0);
        chk({tag, "_qmax"},   32'(o_qmax),    0);
    endtask

    task automatic run_scan(input int stall_rec, input int extra_start_cyc, input int abort_rec);
        int cyc = 1, rec = 0, rd_idx = 0, stall = 0;
        int hs_cyc = -100, done_cyc = -100, done_cnt = 0;
        logic prev_valid = 1'b0;
        logic [5:0] h_s;
        logic [1:0] h_a;
        logic [7:0] h_q;
        logic [9:0] exp_rec;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (cyc < 1000) begin
            start = (cyc == extra_start_cyc);
            if (abort_rec >= 0 && rec == abort_rec && q_rd_en) begin
                rst = 1'b1;
                #1;
                chk_all_zero("abort");
                return;
            end
            if (q_rd_en) begin
                chk("rd_addr", 32'(q_rd_addr), 32'({6'(rec), 2'(rd_idx)}));
                if (rd_idx == 0) chk("rd_start_cyc", cyc, (rec == 0) ? 1 : hs_cyc + 2);
                rd_idx = (rd_idx + 1) % 4;
            end
            if (cyc == hs_cyc + 1) begin
                chk("valid_drop", 32'(o_valid), 0);
                chk("addr_hold", 32'(q_rd_addr), 32'({6'(rec - 1), 2'b11}));
                chk("gap_rd_en", 32'(q_rd_en), 0);
            end
            if (o_valid && !prev_valid) chk("valid_cyc", cyc, (rec == 0) ? 6 : hs_cyc + 7);
            if (o_valid) begin
                if (rec == stall_rec && stall < 10) begin
                    o_ready = 1'b0;
                    if (stall == 0) begin
                        h_s = o_state; h_a = o_action; h_q = o_qmax;
                    end else begin
                        chk("hold_state",  32'(o_state),  32'(h_s));
                        chk("hold_action", 32'(o_action), 32'(h_a));
                        chk("hold_qmax",   32'(o_qmax),   32'(h_q));
                        chk("hold_rd_en",  32'(q_rd_en),  0);
                    end
                    stall++;
                end else begin
                    o_ready = 1'b1;
                    exp_rec = ref_best(rec);
                    chk("rec_state",  32'(o_state),  32'(rec));
                    chk("rec_action", 32'(o_action), 32'(exp_rec[9:8]));
                    chk("rec_qmax",   32'(o_qmax),   32'(exp_rec[7:0]));
                    if (tie_case && rec == 5) begin
                        chk("tie_action", 32'(o_action), 32'h1);
                        chk("tie_qmax",   32'(o_qmax),   32'h50);
                    end
                    hs_cyc = cyc;
                    rec++;
                end
            end else begin
                o_ready = 1'b1;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_cyc", cyc, hs_cyc + 1);
                chk("done_busy", 32'(busy), 1);
            end
            if (cyc == done_cyc + 1) begin
                chk("idle_busy", 32'(busy), 0);
                chk("done_width", 32'(o_done), 0);
                break;
            end
            prev_valid = o_valid;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("record_count", rec, 64);
        chk("done_count", done_cnt, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; o_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy0", 32'(busy), 0);

        // All-zero table: action 0, qmax 0, 64 records
        run_scan(-1, -1, -1);

        // Patterned table, tie at state 5, backpressure on record 3, restart pulse mid-scan
        for (int s = 0; s < 64; s++)
            for (int a = 0; a < 4; a++) mem[s*4+a] = 8'({2'(s), 2'(a)} * 4);
        mem[20] = 8'h30; mem[21] = 8'h50; mem[22] = 8'h50; mem[23] = 8'h10;
        tie_case = 1'b1;
        @(negedge clk);
        run_scan(3, 100, -1);
        tie_case = 1'b0;

        // Reset during record 10 reads aborts the scan
        @(negedge clk);
        run_scan(-1, -1, 10);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_valid || o_done || busy || q_rd_en) chk("post_abort_quiet", 32'({o_valid, o_done, busy, q_rd_en}), 0);
        end
        chk("post_abort_idle", 32'({o_valid, o_done, busy, q_rd_en}), 0);

        // Fresh start after abort scans from state 0 again
        run_scan(-1, -1, -1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/qtable_policy_reader.md
QTABLE_POLICY_READER -- requirements
Module: qtable_policy_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one Q value, unsigned.
REQ-002 Parameter NUM_STATES, default 64: number of grid states scanned, 6-bit state index.
REQ-003 Port clk, input, 1: the only clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port start, input, 1: single-cycle request to begin a full policy scan.
REQ-006 Port busy, output, 1: high from the cycle after start is accepted until the DONE cycle inclusive.
REQ-007 Port q_rd_addr, output, 8: Q-table read address {state[5:0], action[1:0]}.
REQ-008 Port q_rd_en, output, 1: Q-table read enable.
REQ-009 Port q_rd_data, input, DATA_WIDTH: Q-table read data, valid exactly 1 cycle after the q_rd_en cycle.
REQ-010 Port o_valid, output, 1: the output record is valid.
REQ-011 Port o_ready, input, 1: the consumer accepts the record.
REQ-012 Port o_state, output, 6: state index of the record.
REQ-013 Port o_action, output, 2: greedy action (00 left, 01 up, 10 right, 11 down).
REQ-014 Port o_qmax, output, DATA_WIDTH: maximum Q value over the 4 actions.
REQ-015 Port o_done, output, 1: one-cycle pulse after the last record is accepted.

Function
REQ-016 The FSM SHALL have states IDLE, READ, EVAL, OUT, and DONE.
REQ-017 In IDLE, start high SHALL set the state counter to 0 and move to READ; start is ignored in all other states.
REQ-018 In READ, the block SHALL assert q_rd_en for 4 consecutive cycles with q_rd_addr = {s, 00}, {s, 01}, {s, 10}, {s, 11} in that order, then move to EVAL.
REQ-019 Each returned q_rd_data SHALL be captured the cycle after its read: the action-0 value loads best_q/best_a unconditionally, and later values replace them only if strictly greater (unsigned compare).
REQ-020 On a tie, the lowest action index SHALL win.
REQ-021 EVAL SHALL last 1 cycle to capture the action-3 data, then move to OUT with o_valid = 1.
REQ-022 Latency: o_valid SHALL be high in the 6th cycle after the start-accept cycle (4 read cycles + 1 EVAL + OUT).
REQ-023 In OUT, o_state/o_action/o_qmax SHALL hold stable while o_valid && !o_ready.
REQ-024 A handshake SHALL be o_valid && o_ready on a rising edge; o_valid deasserts on the next cycle.
REQ-025 After a handshake with s < NUM_STATES-1, the counter SHALL increment and the FSM SHALL re-enter READ the next cycle (7-cycle record period with o_ready tied high).
REQ-026 After a handshake with s = NUM_STATES-1, the FSM SHALL go to DONE: o_done = 1 for exactly 1 cycle, then IDLE with busy = 0.
REQ-027 The state counter SHALL NOT wrap; exactly NUM_STATES records are produced per scan.
REQ-028 q_rd_en SHALL be 0 outside READ, and q_rd_addr SHALL hold its last value when q_rd_en = 0.
REQ-029 The block SHALL never write the Q table and SHALL leave read/write collision arbitration to the table.

Reset
REQ-030 While rst is high, the block SHALL be in IDLE with busy, q_rd_en, o_valid, and o_done = 0, q_rd_addr = 0, o_state/o_action/o_qmax = 0, and the counter and best registers = 0.
REQ-031 rst asserted mid-scan SHALL abort immediately, emit no further records, and require a new start after release.

Verification
REQ-032 Table all zeros, o_ready = 1, pulse start -> 64 records, state 0..63, action 00, qmax 00; o_done pulses 1 cycle after record 63 is accepted; first o_valid in cycle 6.
REQ-033 Table Q[{s,a}] = {s[1:0], a} × 4 -> every record has action 11 and qmax = {s[1:0], 11} × 4; q_rd_addr sequence matches REQ-018.
REQ-034 State 5 entries 0x30, 0x50, 0x50, 0x10 -> record 5 has action 01 and qmax 0x50 (tie resolves to the lower action).
REQ-035 o_ready low for 10 cycles on record 3 -> o_valid and the payload are held unchanged and q_rd_en stays 0; record 4 reads begin the cycle after the handshake.
REQ-036 rst pulsed during record 10 READ -> all outputs 0 at once, no o_done; a new start restarts from state 0.
REQ-037 start pulsed again while busy -> ignored; exactly 64 records and one o_done.
